// File: rtl/pushbutton_pkg.sv
// Shared constants for the pushbutton AXI4-Lite interrupt block:
// register byte offsets, ID word layout, response encoding, FSM states.
package pushbutton_pkg;

   localparam logic [4:0] OFS_LEVEL   = 5'h00;
   localparam logic [4:0] OFS_RISE_EN = 5'h04;
   localparam logic [4:0] OFS_FALL_EN = 5'h08;
   localparam logic [4:0] OFS_STATUS  = 5'h0C;
   localparam logic [4:0] OFS_IRQ_EN  = 5'h10;
   localparam logic [4:0] OFS_GIE     = 5'h14;
   localparam logic [4:0] OFS_ID      = 5'h18;

   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [15:0] ID_MAGIC   = 16'h5042;
   localparam logic [7:0]  ID_VERSION = 8'd2;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   function automatic logic [31:0] id_word(input int unsigned nbtn);
      return {ID_MAGIC, ID_VERSION, 8'(nbtn)};
   endfunction

   // Expand 4 byte strobes into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
      return m;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level and single-cycle rise/fall pulses aligned with the level flip.
module btn_debounce
   import pushbutton_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          flip;

   // Pulses are combinational so the status register sets on the same
   // edge that the debounced level changes.
   assign flip = (sync[1] != level) && (cnt == CNT_LAST);
   assign rise = flip &  sync[1];
   assign fall = flip & ~sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], btn_raw};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (flip) begin
            cnt   <= '0;
            level <= sync[1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pushbutton_axi_irq.sv
// N-channel debounced pushbutton block behind AXI4-Lite: edge detect,
// sticky W1C status with enables and one registered level interrupt.
module pushbutton_axi_irq
   import pushbutton_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 5,
   parameter int NUM_BTN              = 4,
   parameter int DEBOUNCE_CYCLES      = 1000000
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [NUM_BTN-1:0]                btn_in,
   output logic                              irq,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready
);

   logic [NUM_BTN-1:0] level, rise, fall;
   logic [NUM_BTN-1:0] rise_en, fall_en, status, irq_en;
   logic [NUM_BTN-1:0] wm, wd, status_set, status_clr;
   logic               gie;
   logic [31:0]        wmask, rd_word;
   logic               wr_fire, rd_fire;
   logic               unused_axi;
   wr_state_t          w_state, w_next;
   rd_state_t          r_state, r_next;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (s00_axi_aclk),
         .rst_n   (s00_axi_aresetn),
         .btn_raw (btn_in[i]),
         .level   (level[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   assign wmask = strb_mask(s00_axi_wstrb);
   assign wm    = wmask[NUM_BTN-1:0];
   assign wd    = s00_axi_wdata[NUM_BTN-1:0];
   assign unused_axi = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_wdata, wmask};

   assign s00_axi_bresp = RESP_OKAY;
   assign s00_axi_rresp = RESP_OKAY;

   // Write channel: AW and W are only taken together.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) w_state <= W_IDLE;
      else                  w_state <= w_next;
   end

   always_comb begin
      w_next          = w_state;
      s00_axi_awready = 1'b0;
      s00_axi_wready  = 1'b0;
      s00_axi_bvalid  = 1'b0;
      wr_fire         = 1'b0;
      case (w_state)
         W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) begin
            s00_axi_awready = 1'b1;
            s00_axi_wready  = 1'b1;
            wr_fire         = 1'b1;
            w_next          = W_RESP;
         end
         W_RESP: begin
            s00_axi_bvalid = 1'b1;
            if (s00_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) r_state <= R_IDLE;
      else                  r_state <= r_next;
   end

   always_comb begin
      r_next          = r_state;
      s00_axi_arready = 1'b0;
      s00_axi_rvalid  = 1'b0;
      rd_fire         = 1'b0;
      case (r_state)
         R_IDLE: if (s00_axi_arvalid) begin
            s00_axi_arready = 1'b1;
            rd_fire         = 1'b1;
            r_next          = R_DATA;
         end
         R_DATA: begin
            s00_axi_rvalid = 1'b1;
            if (s00_axi_rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      case ({s00_axi_araddr[4:2], 2'b00})
         OFS_LEVEL:   rd_word = 32'(level);
         OFS_RISE_EN: rd_word = 32'(rise_en);
         OFS_FALL_EN: rd_word = 32'(fall_en);
         OFS_STATUS:  rd_word = 32'(status);
         OFS_IRQ_EN:  rd_word = 32'(irq_en);
         OFS_GIE:     rd_word = {31'b0, gie};
         OFS_ID:      rd_word = id_word(NUM_BTN);
         default:     rd_word = '0;
      endcase
   end

   // A new edge beats a simultaneous W1C of the same bit.
   assign status_set = (rise & rise_en) | (fall & fall_en);
   assign status_clr = (wr_fire && {s00_axi_awaddr[4:2], 2'b00} == OFS_STATUS) ? (wd & wm) : '0;

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rise_en       <= '0;
         fall_en       <= '0;
         status        <= '0;
         irq_en        <= '0;
         gie           <= 1'b0;
         irq           <= 1'b0;
         s00_axi_rdata <= '0;
      end else begin
         if (wr_fire) begin
            case ({s00_axi_awaddr[4:2], 2'b00})
               OFS_RISE_EN: rise_en <= (rise_en & ~wm) | (wd & wm);
               OFS_FALL_EN: fall_en <= (fall_en & ~wm) | (wd & wm);
               OFS_IRQ_EN:  irq_en  <= (irq_en  & ~wm) | (wd & wm);
               OFS_GIE:     if (s00_axi_wstrb[0]) gie <= s00_axi_wdata[0];
               default: ;
            endcase
         end
         status <= (status & ~status_clr) | status_set;
         irq    <= gie & (|(status & irq_en));
         if (rd_fire) s00_axi_rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_pushbutton_axi_irq.sv
// Randomised bench for pushbutton_axi_irq with a cycle-level behavioural
// model (window-based debounce rule) and per-cycle output comparison.
module tb_pushbutton_axi_irq;

   localparam int NB = 4;
   localparam int DC = 8;

   logic          tb_ACLK = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_in;
   logic          irq;
   logic [4:0]    awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 tb_ACLK = ~tb_ACLK;

   pushbutton_axi_irq #(
      .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(5),
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .s00_axi_aclk(tb_ACLK), .s00_axi_aresetn(rst_n), .btn_in(btn_in), .irq(irq),
      .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
      .s00_axi_wready(wready), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
      .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid),
      .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
      .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NB-1:0] m_level, m_rise_en, m_fall_en, m_status, m_irq_en;
   logic          m_gie, m_irq, m_wbusy, m_rbusy;
   logic [31:0]   m_rdata;
   logic [NB-1:0] hist[$];   // raw button samples, oldest first

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a[4:2])
         3'd0: return 32'(m_level);
         3'd1: return 32'(m_rise_en);
         3'd2: return 32'(m_fall_en);
         3'd3: return 32'(m_status);
         3'd4: return 32'(m_irq_en);
         3'd5: return {31'b0, m_gie};
         3'd6: return {16'h5042, 8'd2, 8'(NB)};
         default: return 32'h0;
      endcase
   endfunction

   // A level flips once the DC most recent synchronised samples (raw sample
   // two edges old and earlier) all disagree with it.
   task automatic model_step();
      logic [NB-1:0] nl, setb, clr;
      logic [31:0]   msk;
      logic          all_diff, acc_w, acc_r;
      if (!rst_n) begin
         m_level = '0; m_rise_en = '0; m_fall_en = '0; m_status = '0; m_irq_en = '0;
         m_gie = 1'b0; m_irq = 1'b0; m_wbusy = 1'b0; m_rbusy = 1'b0; m_rdata = '0;
         hist.delete();
         repeat (DC + 2) hist.push_back('0);
         return;
      end
      hist.push_back(btn_in);
      if (hist.size() > DC + 2) void'(hist.pop_front());
      nl = m_level;
      for (int i = 0; i < NB; i++) begin
         all_diff = 1'b1;
         for (int k = 0; k < DC; k++) if (hist[k][i] == m_level[i]) all_diff = 1'b0;
         if (all_diff) nl[i] = ~m_level[i];
      end
      setb  = (nl & ~m_level & m_rise_en) | (~nl & m_level & m_fall_en);
      acc_w = !m_wbusy && awvalid && wvalid;
      acc_r = !m_rbusy && arvalid;
      for (int b = 0; b < 4; b++) msk[b*8 +: 8] = {8{wstrb[b]}};
      clr   = '0;
      m_irq = m_gie & (|(m_status & m_irq_en));
      if (acc_r) m_rdata = m_read(araddr);
      if (acc_w) begin
         case (awaddr[4:2])
            3'd1: m_rise_en = (m_rise_en & ~msk[NB-1:0]) | (wdata[NB-1:0] & msk[NB-1:0]);
            3'd2: m_fall_en = (m_fall_en & ~msk[NB-1:0]) | (wdata[NB-1:0] & msk[NB-1:0]);
            3'd3: clr = wdata[NB-1:0] & msk[NB-1:0];
            3'd4: m_irq_en = (m_irq_en & ~msk[NB-1:0]) | (wdata[NB-1:0] & msk[NB-1:0]);
            3'd5: if (wstrb[0]) m_gie = wdata[0];
            default: ;
         endcase
      end
      m_status = (m_status & ~clr) | setb;
      m_level  = nl;
      if (m_wbusy) begin if (bready) m_wbusy = 1'b0; end
      else if (acc_w) m_wbusy = 1'b1;
      if (m_rbusy) begin if (rready) m_rbusy = 1'b0; end
      else if (acc_r) m_rbusy = 1'b1;
   endtask

   always @(posedge tb_ACLK) model_step();

   always @(negedge tb_ACLK) begin
      if (rst_n === 1'b1) begin
         chk("irq", irq, m_irq);
         chk("awready", awready, !m_wbusy && awvalid && wvalid);
         chk("wready", wready, !m_wbusy && awvalid && wvalid);
         chk("bvalid", bvalid, m_wbusy);
         chk("arready", arready, !m_rbusy && arvalid);
         chk("rvalid", rvalid, m_rbusy);
         chk("rdata", rdata, m_rdata);
         chk("bresp", bresp, 2'b00);
         chk("rresp", rresp, 2'b00);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge tb_ACLK); #1;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      int t;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      t = 0;
      do begin @(negedge tb_ACLK); t++; end while (!(awready && wready) && t < 20);
      if (!(awready && wready)) chk("aw_timeout", awready && wready, 1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      t = 0;
      do begin @(negedge tb_ACLK); t++; end while (!bvalid && t < 20);
      if (!bvalid) chk("b_timeout", bvalid, 1);
      tick();
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
      int t;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      t = 0;
      do begin @(negedge tb_ACLK); t++; end while (!arready && t < 20);
      if (!arready) chk("ar_timeout", arready, 1);
      tick();
      arvalid = 1'b0;
      t = 0;
      do begin @(negedge tb_ACLK); t++; end while (!rvalid && t < 20);
      if (!rvalid) chk("r_timeout", rvalid, 1);
      d = rdata;
      tick();
   endtask

   initial begin
      logic [31:0] d;
      logic        aw_hs, ar_hs;
      int          idx;
      rst_n = 1'b0; btn_in = '0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge tb_ACLK);
      #1 rst_n = 1'b1;

      // Reset values of the whole map
      for (int a = 0; a < 8; a++) begin
         axi_read(5'(a * 4), d);
         chk($sformatf("reset_rd_%0h", a * 4), d, (a == 6) ? 32'h50420204 : 32'h0);
      end

      // Debounce latency on channel 1
      axi_write(5'h04, 32'h2, 4'hF);
      btn_in = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 9)  chk("model_lvl_at_9", m_level, 4'h0);
         if (k == 10) chk("model_lvl_at_10", m_level, 4'h2);
      end
      axi_read(5'h00, d); chk("level_ch1", d, 32'h2);
      axi_read(5'h0C, d); chk("status_ch1", d, 32'h2);

      // Short glitch on channel 0 is rejected
      btn_in = 4'b0011;
      repeat (5) tick();
      btn_in = 4'b0010;
      repeat (15) tick();
      axi_read(5'h00, d); chk("glitch_level", d, 32'h2);
      axi_read(5'h0C, d); chk("glitch_status", d, 32'h2);

      // Interrupt enable and W1C
      axi_write(5'h10, 32'h2, 4'hF);
      axi_write(5'h14, 32'h1, 4'hF);
      chk("irq_on", irq, 1);
      axi_write(5'h0C, 32'h2, 4'hF);
      chk("irq_off", irq, 0);
      axi_read(5'h0C, d); chk("status_cleared", d, 32'h0);

      // W1C of bit 0 on the same edge channel 0 debounces high
      axi_write(5'h04, 32'h3, 4'hF);
      btn_in = 4'b0011;
      repeat (9) tick();
      awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      tick();
      chk("model_set_edge", m_level, 4'h3);
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      axi_read(5'h0C, d); chk("set_wins", d, 32'h1);

      // Byte strobes: lane 0 disabled leaves RISE_EN untouched
      axi_write(5'h04, 32'hF, 4'b1110);
      axi_read(5'h04, d); chk("strb_masked", d, 32'h3);

      // AW ahead of W, slow B acceptance
      bready = 1'b0; awaddr = 5'h08; wdata = 32'h5; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b0;
      repeat (3) begin
         @(negedge tb_ACLK);
         chk("aw_alone_awready", awready, 0);
         chk("aw_alone_wready", wready, 0);
         tick();
      end
      wvalid = 1'b1;
      @(negedge tb_ACLK);
      chk("both_awready", awready, 1);
      chk("both_wready", wready, 1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (4) begin @(negedge tb_ACLK); chk("bvalid_hold", bvalid, 1); tick(); end
      bready = 1'b1;
      @(negedge tb_ACLK); chk("bvalid_last", bvalid, 1);
      tick();
      @(negedge tb_ACLK); chk("bvalid_done", bvalid, 0);
      tick();
      axi_read(5'h08, d); chk("fall_en", d, 32'h5);

      // Reset in the middle of a read response
      araddr = 5'h18; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      @(negedge tb_ACLK); chk("rvalid_pre_rst", rvalid, 1);
      tick();
      rst_n = 1'b0;
      #2;
      chk("rvalid_in_rst", rvalid, 0);
      chk("irq_in_rst", irq, 0);
      repeat (2) @(posedge tb_ACLK);
      #1 rst_n = 1'b1; rready = 1'b1;
      axi_read(5'h04, d); chk("rise_en_after_rst", d, 32'h0);
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
      axi_read(5'h1C, d); chk("reserved_rd", d, 32'h0);

      // Randomised traffic, every cycle checked against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge tb_ACLK);
         aw_hs = awvalid && awready;
         ar_hs = arvalid && arready;
         tick();
         if (aw_hs) begin awvalid = 1'b0; wvalid = 1'b0; end
         if (ar_hs) arvalid = 1'b0;
         if (!awvalid && $urandom_range(0, 3) == 0) begin
            awaddr  = {3'($urandom_range(0, 7)), 2'b00};
            wdata   = $urandom;
            wstrb   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            awvalid = 1'b1; wvalid = 1'b1;
         end
         if (!arvalid && $urandom_range(0, 2) == 0) begin
            araddr  = {3'($urandom_range(0, 7)), 2'b00};
            arvalid = 1'b1;
         end
         bready = ($urandom_range(0, 2) != 0);
         rready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 11) == 0) begin
            idx = $urandom_range(0, NB - 1);
            btn_in[idx] = ~btn_in[idx];
         end
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
